muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The module SHALL have parameter CYCLES, default 32, giving the number of iteration (STEP) cycles per operation; legal range 2..63.
REQ-002 The module SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have the port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The module SHALL have the port start, input, 1 bit: operation request from the main control unit.
REQ-005 The module SHALL have the port op, input, 1 bit: 0 = MULT, 1 = DIV; sampled only when start is accepted.
REQ-006 The module SHALL have the port b_is_zero, input, 1 bit: divisor-equals-zero flag; sampled only when start is accepted with op=1.
REQ-007 The module SHALL have the port abort, input, 1 bit: cancels an in-flight operation.
REQ-008 The module SHALL have the ports multControl and divControl, output, 2 bits each: 00 idle, 01 init/load operands, 10 iterate one step.
REQ-009 The module SHALL have the ports himultControl, lomultControl, hidivControl and lodivControl, output, 1 bit each: HI/LO register load enables.
REQ-010 The module SHALL have the ports busy, done and div0, output, 1 bit each: busy flag, completion pulse and divide-by-zero exception pulse.

Function
REQ-011 The FSM SHALL have the states IDLE, INIT, STEP, WRITE, DONE and ZERO, and all outputs SHALL be decoded from the state register only (Moore).
REQ-012 In IDLE, start=1 SHALL be accepted and op latched into op_q; the next state SHALL be ZERO if op=1 and b_is_zero=1, else INIT.
REQ-013 b_is_zero SHALL be ignored when op=0.
REQ-014 In INIT, the selected unit's control SHALL equal 01 for exactly one cycle, the iteration counter SHALL clear to 0, and the next state SHALL be STEP.
REQ-015 In STEP, the selected unit's control SHALL equal 10 and the counter SHALL increment each cycle.
REQ-016 The STEP-to-WRITE transition SHALL occur on the edge where the counter equals CYCLES-1, so that STEP lasts exactly CYCLES cycles.
REQ-017 The counter SHALL be 6 bits wide and SHALL never wrap within an operation.
REQ-018 In WRITE, himultControl and lomultControl (op_q=0) or hidivControl and lodivControl (op_q=1) SHALL be 1 for exactly one cycle, and the next state SHALL be DONE.
REQ-019 In DONE, done SHALL be 1 for one cycle, and the next state SHALL be IDLE.
REQ-020 In ZERO, div0 SHALL be 1 for one cycle with no control code other than 00 and no HI/LO enable, and the next state SHALL be IDLE; done SHALL NOT assert.
REQ-021 The non-selected unit's control SHALL remain 00 and its HI/LO enables SHALL remain 0 throughout an operation.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 A start asserted while busy=1 (including during DONE) SHALL be ignored, and op_q SHALL be unchanged.
REQ-024 With start accepted in cycle 0, the timing SHALL be: INIT in cycle 1, STEP in cycles 2..CYCLES+1, WRITE in cycle CYCLES+2, DONE in cycle CYCLES+3, and IDLE in cycle CYCLES+4.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE at the next edge.
REQ-026 abort SHALL NOT suppress the outputs of the current cycle, and a WRITE that has not yet been reached SHALL never occur.
REQ-027 abort SHALL have no effect in IDLE, and start SHALL be ignored in a cycle where abort=1.
REQ-028 Priority SHALL be reset > abort > start.

Reset
REQ-029 reset=1 at a clock edge SHALL set the state to IDLE, the counter to 0 and op_q to 0, regardless of the current state (including mid-operation).
REQ-030 Following reset, all control outputs SHALL be 00 and all enable, busy, done and div0 outputs SHALL be 0 from the next cycle.
REQ-031 An operation interrupted by reset SHALL produce no HI/LO write.

Verification
REQ-032 MULT, CYCLES=32, start+op=0 in cycle 0 -> multControl=01 in cycle 1, 10 in cycles 2..33; himultControl=lomultControl=1 in cycle 34; done=1 in cycle 35; divControl=00 throughout.
REQ-033 DIV, op=1, b_is_zero=0 -> same timing on divControl, hidivControl and lodivControl; mult outputs stay 0.
REQ-034 DIV with b_is_zero=1 -> div0=1 in cycle 1 only; no HI/LO enable, no done; busy=0 in cycle 2.
REQ-035 MULT started in cycle 0, then start with op=1 in cycle 10 -> request ignored; himult/lomult pulse in cycle 34; no div activity.
REQ-036 DIV started, reset=1 in cycle 20 -> cycle 21: IDLE, all outputs 0; no hidiv/lodiv pulse ever.
REQ-037 MULT started, abort=1 in cycle 15 -> IDLE in cycle 16; no HI/LO enable, no done; a new start in cycle 16 is accepted normally.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Control bundle between the main control unit and the mult/div sequencer.
// Purely combinational wiring, no latency.
// No backpressure: requests made while the sequencer is busy are dropped.
interface muldiv_sequencer_if;
  logic       start;
  logic       op;
  logic       b_is_zero;
  logic       abort;
  logic [1:0] multControl;
  logic [1:0] divControl;
  logic       himultControl;
  logic       lomultControl;
  logic       hidivControl;
  logic       lodivControl;
  logic       busy;
  logic       done;
  logic       div0;

  // Control-unit side: issues requests, observes the datapath controls.
  modport master (
    output start, op, b_is_zero, abort,
    input  multControl, divControl, himultControl, lomultControl,
    input  hidivControl, lodivControl, busy, done, div0
  );

  // Sequencer side.
  modport slave (
    input  start, op, b_is_zero, abort,
    output multControl, divControl, himultControl, lomultControl,
    output hidivControl, lodivControl, busy, done, div0
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Moore sequencer driving an iterative multiply/divide datapath: INIT, CYCLES steps, HI/LO write, done.
// Latency: CYCLES+4 cycles from accepted start back to idle; divide-by-zero returns after 2 cycles.
// No backpressure: start is only honoured in IDLE without abort; abort returns to IDLE on the next edge.
module muldiv_sequencer #(
  parameter int CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  muldiv_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_STEP  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ZERO  = 3'd5
  } state_t;

  // Last counter value seen in STEP; leaving on this value gives exactly CYCLES steps.
  localparam logic [5:0] LAST_STEP = 6'(CYCLES - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       op_q, op_d;

  // State, iteration counter and latched operation, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; abort overrides any progress outside IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          op_d    = bus.op;
          state_d = (bus.op && bus.b_is_zero) ? S_ZERO : S_INIT;
        end
      end
      S_INIT: begin
        cnt_d   = 6'd0;
        state_d = S_STEP;
      end
      S_STEP: begin
        // CYCLES <= 63 keeps this below the 6-bit wrap point.
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) state_d = S_WRITE;
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ZERO:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Moore output decode: only the unit named by op_q ever sees a non-idle code.
  logic [1:0] unit_ctl;
  logic       hilo_we;

  assign unit_ctl = (state_q == S_INIT) ? 2'b01 :
                    (state_q == S_STEP) ? 2'b10 : 2'b00;
  assign hilo_we  = (state_q == S_WRITE);

  assign bus.multControl   = op_q ? 2'b00 : unit_ctl;
  assign bus.divControl    = op_q ? unit_ctl : 2'b00;
  assign bus.himultControl = hilo_we && !op_q;
  assign bus.lomultControl = hilo_we && !op_q;
  assign bus.hidivControl  = hilo_we && op_q;
  assign bus.lodivControl  = hilo_we && op_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.div0          = (state_q == S_ZERO);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scenario table plus randomized run against a timeline model.
// The model tracks "cycles since accepted start" rather than any FSM state.
// Inputs driven on the falling edge, outputs sampled on the falling edge after each rising edge.
module tb_muldiv_sequencer;

  localparam int C = 32;
  localparam int W = 60;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.CYCLES(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: an operation is a timeline indexed by cycles since acceptance.
  bit m_active = 1'b0;
  int m_k      = 0;
  bit m_op     = 1'b0;
  bit m_zero   = 1'b0;

  task automatic model_step(input bit rst, input bit st, input bit o, input bit bz, input bit ab);
    if (rst) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (ab) m_active = 1'b0;
      else begin
        m_k++;
        if (m_zero && m_k > 1) m_active = 1'b0;
        else if (m_k >= C + 4) m_active = 1'b0;
      end
    end else if (st && !ab) begin
      m_active = 1'b1;
      m_k      = 1;
      m_op     = o;
      m_zero   = o && bz;
    end
  endtask

  // {multControl, divControl, himult, lomult, hidiv, lodiv, busy, done, div0}
  function automatic logic [10:0] exp_out();
    logic [1:0] ctl;
    logic hl, dn, z;
    ctl = 2'b00; hl = 1'b0; dn = 1'b0; z = 1'b0;
    if (m_active) begin
      if (m_zero) z = (m_k == 1);
      else begin
        if (m_k == 1) ctl = 2'b01;
        else if (m_k >= 2 && m_k <= C + 1) ctl = 2'b10;
        hl = (m_k == C + 2);
        dn = (m_k == C + 3);
      end
    end
    return {m_op ? 2'b00 : ctl, m_op ? ctl : 2'b00,
            !m_op && hl, !m_op && hl, m_op && hl, m_op && hl,
            m_active, dn, z};
  endfunction

  function automatic logic [10:0] got_out();
    return {bus.multControl, bus.divControl, bus.himultControl, bus.lomultControl,
            bus.hidivControl, bus.lodivControl, bus.busy, bus.done, bus.div0};
  endfunction

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // One clock: model follows the inputs that the DUT samples, then outputs are compared.
  task automatic tick(input string name);
    logic [10:0] g, e;
    @(posedge clk);
    model_step(reset, bus.start, bus.op, bus.b_is_zero, bus.abort);
    @(negedge clk);
    g = got_out();
    e = exp_out();
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s outputs got=%b expected=%b (t=%0t)", name, g, e, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = 1'b0; bus.b_is_zero = 1'b0; bus.abort = 1'b0; reset = 1'b0;
  endtask

  typedef struct {
    string name;
    bit    op;
    bit    bz;
    int    abort_cyc;
    int    reset_cyc;
    int    s2_cyc;
    bit    s2_op;
    int    exp_mwr;    // first cycle with himult/lomult, -1 = never
    int    exp_dwr;    // first cycle with hidiv/lodiv
    int    exp_done;
    int    exp_div0;
    int    exp_nwr;    // number of HI/LO write cycles in the window
  } scn_t;

  task automatic run_scn(input scn_t s);
    int mwr, dwr, dn, z, nwr;
    mwr = -1; dwr = -1; dn = -1; z = -1; nwr = 0;
    for (int c = 0; c < W; c++) begin
      bus.start     = (c == 0) || (c == s.s2_cyc);
      bus.op        = (c == 0) ? s.op : s.s2_op;
      bus.b_is_zero = (c == 0) ? s.bz : 1'b0;
      bus.abort     = (c == s.abort_cyc);
      reset         = (c == s.reset_cyc);
      tick(s.name);
      if ((bus.himultControl || bus.lomultControl) && mwr < 0) mwr = c + 1;
      if ((bus.hidivControl || bus.lodivControl) && dwr < 0) dwr = c + 1;
      if (bus.done && dn < 0) dn = c + 1;
      if (bus.div0 && z < 0) z = c + 1;
      if (bus.himultControl || bus.lomultControl || bus.hidivControl || bus.lodivControl) nwr++;
    end
    check_int({s.name, ".mult_write_cyc"}, mwr, s.exp_mwr);
    check_int({s.name, ".div_write_cyc"}, dwr, s.exp_dwr);
    check_int({s.name, ".done_cyc"}, dn, s.exp_done);
    check_int({s.name, ".div0_cyc"}, z, s.exp_div0);
    check_int({s.name, ".write_count"}, nwr, s.exp_nwr);
    idle_inputs();
    reset = 1'b1;
    tick({s.name, ".reset"});
    reset = 1'b0;
  endtask

  scn_t tbl[8];

  initial begin
    //         name         op bz  abort rst  s2  s2op  mwr  dwr done div0 nwr
    tbl[0] = '{"mult",       0, 0,  -1,  -1,  -1, 0,    34,  -1, 35,  -1, 1};
    tbl[1] = '{"div",        1, 0,  -1,  -1,  -1, 0,    -1,  34, 35,  -1, 1};
    tbl[2] = '{"div0",       1, 1,  -1,  -1,  -1, 0,    -1,  -1, -1,   1, 0};
    tbl[3] = '{"busy_start", 0, 0,  -1,  -1,  10, 1,    34,  -1, 35,  -1, 1};
    tbl[4] = '{"div_reset",  1, 0,  -1,  20,  -1, 0,    -1,  -1, -1,  -1, 0};
    tbl[5] = '{"abort",      0, 0,  15,  -1,  16, 0,    50,  -1, 51,  -1, 1};
    tbl[6] = '{"abort_idle", 0, 0,   0,  -1,  -1, 0,    -1,  -1, -1,  -1, 0};
    tbl[7] = '{"done_start", 0, 0,  -1,  -1,  35, 1,    34,  -1, 35,  -1, 1};

    idle_inputs();
    reset = 1'b1;
    tick("reset0");
    tick("reset1");
    reset = 1'b0;
    check_int("reset_outputs_zero", int'(got_out()), 0);
    tick("idle");

    foreach (tbl[i]) run_scn(tbl[i]);

    // Hand sequence: div0 must drop busy in cycle 2, and a fresh MULT right after must start cleanly.
    bus.start = 1'b1; bus.op = 1'b1; bus.b_is_zero = 1'b1;
    tick("z_c1");
    check_int("z_div0_c1", int'(bus.div0), 1);
    idle_inputs();
    tick("z_c2");
    check_int("z_busy_c2", int'(bus.busy), 0);
    bus.start = 1'b1; bus.b_is_zero = 1'b1;   // op=0: b_is_zero must be ignored
    tick("m_c1");
    check_int("m_ctrl_c1", int'(bus.multControl), 1);
    idle_inputs();
    tick("m_c2");
    check_int("m_ctrl_c2", int'(bus.multControl), 2);
    reset = 1'b1;
    tick("m_reset");
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      bus.start     = ($urandom % 3) == 0;
      bus.op        = $urandom % 2;
      bus.b_is_zero = ($urandom % 4) == 0;
      bus.abort     = ($urandom % 40) == 0;
      reset         = ($urandom % 300) == 0;
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
